// File: rtl/riscv_pkg.sv
// Shared core definitions: execute-stage ALU opcodes and the load/store unit state encoding.
package riscv_pkg;

   localparam int unsigned ALUOP_W = 5;

   typedef logic [ALUOP_W-1:0] aluop_t;

   localparam aluop_t OP_AND  = 5'b00000;
   localparam aluop_t OP_OR   = 5'b00001;
   localparam aluop_t OP_XOR  = 5'b00010;
   localparam aluop_t OP_SLL  = 5'b00100;
   localparam aluop_t OP_SRL  = 5'b00101;
   localparam aluop_t OP_SRA  = 5'b00110;
   localparam aluop_t OP_SLT  = 5'b01000;
   localparam aluop_t OP_SLTU = 5'b01001;
   localparam aluop_t OP_ADD  = 5'b01101;
   localparam aluop_t OP_SUB  = 5'b01110;
   localparam aluop_t OP_LUI  = 5'b10000;
   localparam aluop_t OP_LW   = 5'b10100;
   localparam aluop_t OP_SW   = 5'b10101;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StResp,
      StDone
   } lsu_state_e;

   function automatic logic is_mem_op(input aluop_t op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/lsu_timeout_cnt.sv
// Cycle counter for an outstanding memory access; flags when the access has used its budget.
module lsu_timeout_cnt #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == CntLast);

   // Holds at the last value so it never wraps back into the budget.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lsu_mem.sv
// Load/store unit: runs one req/gnt/rvalid data-memory transaction per lw/sw and stalls the core
// until it completes, flagging misaligned or timed-out accesses.
module lsu_mem
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid_i,
   input  logic [4:0]        ALUop_i,
   input  logic [ADDR_W-1:0] ALUOut,
   input  logic [31:0]       DataOutReg2,
   output logic              stall_o,
   output logic              lsu_done_o,
   output logic              lsu_err_o,
   output logic [31:0]       LoadData,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [31:0]       mem_rdata_i
);

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       load_q, load_d;
   logic              err_q, err_d;
   logic              start;
   logic              busy;
   logic              expired;
   logic              stall;

   assign start = ex_valid_i && is_mem_op(ALUop_i);
   assign busy  = (state_q == StReq) || (state_q == StResp);

   lsu_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!busy),
      .enable  (busy),
      .expired (expired)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      load_d  = '0;
      stall   = 1'b0;

      unique case (state_q)
         StIdle: begin
            err_d = 1'b0;
            if (start) begin
               stall = 1'b1;
               if (ALUOut[1:0] == 2'b00) begin
                  addr_d  = ALUOut;
                  we_d    = (ALUop_i == OP_SW);
                  wdata_d = (ALUop_i == OP_SW) ? DataOutReg2 : '0;
                  state_d = StReq;
               end else begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end
            end
         end
         StReq: begin
            stall = 1'b1;
            // A grant in the expiring cycle is abandoned; its late response lands in IDLE.
            if (expired) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else if (mem_gnt_i) begin
               state_d = StResp;
            end
         end
         StResp: begin
            stall = 1'b1;
            if (mem_rvalid_i) begin
               load_d  = we_q ? '0 : mem_rdata_i;
               state_d = StDone;
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            err_d   = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Keep the memory bus quiet once the access is over.
      if (state_d == StDone) begin
         addr_d  = '0;
         we_d    = 1'b0;
         wdata_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         load_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         load_q  <= load_d;
         err_q   <= err_d;
      end
   end

   assign stall_o     = stall;
   assign lsu_done_o  = (state_q == StDone);
   assign lsu_err_o   = (state_q == StDone) && err_q;
   assign LoadData    = load_q;
   assign mem_req_o   = (state_q == StReq);
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

   a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (mem_req_o && !mem_gnt_i && !expired) |=>
         (mem_req_o && $stable(mem_addr_o) && $stable(mem_we_o) && $stable(mem_wdata_o)));

   a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
      lsu_done_o |=> !lsu_done_o);

   a_no_stall_in_done: assert property (@(posedge clk) disable iff (!rst_n)
      lsu_done_o |-> !stall_o && !mem_req_o);

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: a start-cycle vector table plus multi-cycle transaction sequences.
module tb_lsu_mem;

   localparam logic [4:0] LW  = 5'b10100;
   localparam logic [4:0] SW  = 5'b10101;
   localparam logic [4:0] ADD = 5'b01101;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid_i = 1'b0;
   logic [4:0]  ALUop_i = '0;
   logic [31:0] ALUOut = '0;
   logic [31:0] DataOutReg2 = '0;
   logic        stall_o, lsu_done_o, lsu_err_o, mem_req_o, mem_we_o;
   logic [31:0] LoadData, mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   lsu_mem #(
      .TIMEOUT (8),
      .ADDR_W  (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_valid_i   (ex_valid_i),
      .ALUop_i      (ALUop_i),
      .ALUOut       (ALUOut),
      .DataOutReg2  (DataOutReg2),
      .stall_o      (stall_o),
      .lsu_done_o   (lsu_done_o),
      .lsu_err_o    (lsu_err_o),
      .LoadData     (LoadData),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   typedef struct {
      logic        ev;
      logic [4:0]  op;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      logic        exp_stall;
      logic        exp_req;
      logic        exp_we;
      logic        exp_done;
      logic        exp_err;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_load;
   } vec_t;

   typedef struct {
      int          stall_n;
      int          req_n;
      int          done_c;
      int          done_n;
      int          bus_bad;
      logic        err;
      logic [31:0] ld;
   } seq_res_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      ex_valid_i   = 1'b0;
      ALUop_i      = '0;
      ALUOut       = '0;
      DataOutReg2  = '0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, {27'd0, stall_o, lsu_done_o, lsu_err_o, mem_req_o, mem_we_o}, 32'd0);
      check({tag, "_addr"}, mem_addr_o, 32'd0);
      check({tag, "_wdata"}, mem_wdata_o, 32'd0);
      check({tag, "_load"}, LoadData, 32'd0);
   endtask

   // Called just after a rising edge with the DUT idle; ex_valid stays up until the done cycle.
   task automatic run_seq(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] gnt_m, input logic [31:0] rv_m,
                          input logic [31:0] rdata, input int ncyc, output seq_res_t r);
      logic        exp_we;
      logic [31:0] exp_wd;
      exp_we = (op == SW);
      exp_wd = (op == SW) ? wd : 32'd0;
      r = '{stall_n: 0, req_n: 0, done_c: -1, done_n: 0, bus_bad: 0, err: 1'b0, ld: 32'd0};
      for (int c = 0; c < ncyc; c++) begin
         ex_valid_i   = (r.done_n == 0);
         ALUop_i      = op;
         ALUOut       = addr;
         DataOutReg2  = wd;
         mem_gnt_i    = gnt_m[c];
         mem_rvalid_i = rv_m[c];
         mem_rdata_i  = rv_m[c] ? rdata : (32'hBAD0_0000 | c);
         @(negedge clk);
         if (stall_o) r.stall_n++;
         if (mem_req_o) begin
            r.req_n++;
            if (mem_addr_o !== addr || mem_we_o !== exp_we || mem_wdata_o !== exp_wd)
               r.bus_bad++;
         end
         if (lsu_done_o) begin
            r.done_n++;
            r.done_c = c;
            r.err    = lsu_err_o;
            r.ld     = LoadData;
         end
         @(posedge clk);
         #1;
      end
      drive_idle();
   endtask

   task automatic cmp_seq(input string tag, input seq_res_t got, input seq_res_t exp);
      check({tag, "_stall_cycles"}, got.stall_n, exp.stall_n);
      check({tag, "_req_cycles"}, got.req_n, exp.req_n);
      check({tag, "_done_cycle"}, got.done_c, exp.done_c);
      check({tag, "_done_count"}, got.done_n, exp.done_n);
      check({tag, "_bus_stable"}, got.bus_bad, exp.bus_bad);
      check({tag, "_err"}, {31'd0, got.err}, {31'd0, exp.err});
      check({tag, "_loaddata"}, got.ld, exp.ld);
   endtask

   vec_t     vecs[11];
   seq_res_t res;

   initial begin
      //         ev  op    addr           wd             rdata          st rq we dn er addr           wdata          load
      vecs[0]  = '{1, LW,  32'h0000_1000, 32'hAAAA_AAAA, 32'hDEAD_BEEF, 1, 1, 0, 0, 0, 32'h0000_1000, 32'h0,         32'hDEAD_BEEF};
      vecs[1]  = '{1, SW,  32'h0000_0020, 32'h1234_5678, 32'h5555_5555, 1, 1, 1, 0, 0, 32'h0000_0020, 32'h1234_5678, 32'h0};
      vecs[2]  = '{1, LW,  32'h0000_1002, 32'h0,         32'h0,         1, 0, 0, 1, 1, 32'h0,         32'h0,         32'h0};
      vecs[3]  = '{1, SW,  32'h0000_0021, 32'h0000_FFFF, 32'h0,         1, 0, 0, 1, 1, 32'h0,         32'h0,         32'h0};
      vecs[4]  = '{1, ADD, 32'h0000_1000, 32'h1,         32'h0,         0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0};
      vecs[5]  = '{0, LW,  32'h0000_1000, 32'h0,         32'h0,         0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0};
      vecs[6]  = '{0, SW,  32'h0000_0020, 32'h9,         32'h0,         0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0};
      vecs[7]  = '{1, 5'b10110, 32'h40,   32'h0,         32'h0,         0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0};
      vecs[8]  = '{1, LW,  32'hFFFF_FFFC, 32'h0,         32'h0000_0001, 1, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0001};
      vecs[9]  = '{1, SW,  32'h0000_0100, 32'hCAFE_F00D, 32'h0000_0077, 1, 1, 1, 0, 0, 32'h0000_0100, 32'hCAFE_F00D, 32'h0};
      vecs[10] = '{1, LW,  32'h0000_0003, 32'h0,         32'h0,         1, 0, 0, 1, 1, 32'h0,         32'h0,         32'h0};

      drive_idle();
      #12;
      check_all_zero("reset");
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         ex_valid_i  = vecs[i].ev;
         ALUop_i     = vecs[i].op;
         ALUOut      = vecs[i].addr;
         DataOutReg2 = vecs[i].wd;
         @(negedge clk);
         check($sformatf("v%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].exp_stall});
         @(posedge clk);
         #1;
         ex_valid_i = 1'b0;
         mem_gnt_i  = vecs[i].exp_req;
         @(negedge clk);
         check($sformatf("v%0d_req", i), {31'd0, mem_req_o}, {31'd0, vecs[i].exp_req});
         check($sformatf("v%0d_we", i), {31'd0, mem_we_o}, {31'd0, vecs[i].exp_we});
         check($sformatf("v%0d_addr", i), mem_addr_o, vecs[i].exp_addr);
         check($sformatf("v%0d_wdata", i), mem_wdata_o, vecs[i].exp_wdata);
         check($sformatf("v%0d_done", i), {31'd0, lsu_done_o}, {31'd0, vecs[i].exp_done});
         check($sformatf("v%0d_err", i), {31'd0, lsu_err_o}, {31'd0, vecs[i].exp_err});
         check($sformatf("v%0d_stall2", i), {31'd0, stall_o}, {31'd0, vecs[i].exp_req});
         if (vecs[i].exp_req) begin
            @(posedge clk);
            #1;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("v%0d_req_drop", i), {31'd0, mem_req_o}, 32'd0);
            @(posedge clk);
            #1;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            @(negedge clk);
            check($sformatf("v%0d_resp_done", i), {30'd0, lsu_done_o, lsu_err_o}, 32'd2);
            check($sformatf("v%0d_load", i), LoadData, vecs[i].exp_load);
         end else begin
            check($sformatf("v%0d_load0", i), LoadData, 32'd0);
         end
         @(posedge clk);
         #1;
         @(negedge clk);
         check($sformatf("v%0d_idle_done", i), {31'd0, lsu_done_o}, 32'd0);
         @(posedge clk);
         #1;
      end

      // Zero-wait load: three stall cycles, done on the third cycle after start.
      run_seq(LW, 32'h1000, 32'h0, 32'h2, 32'h4, 32'hDEAD_BEEF, 8, res);
      cmp_seq("lw_zero_wait", res, '{3, 1, 3, 1, 0, 1'b0, 32'hDEAD_BEEF});

      // Store with late grant; an early rvalid while still requesting must be ignored.
      run_seq(SW, 32'h20, 32'h1234_5678, 32'h10, 32'h44, 32'h0, 12, res);
      cmp_seq("sw_delayed", res, '{7, 4, 7, 1, 0, 1'b0, 32'h0});

      run_seq(LW, 32'h1002, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5, res);
      cmp_seq("lw_misaligned", res, '{1, 0, 1, 1, 0, 1'b1, 32'h0});

      // Timeout in RESP, then a stale rvalid arriving in IDLE.
      run_seq(LW, 32'h1000, 32'h0, 32'h2, 32'h800, 32'h1111_1111, 14, res);
      cmp_seq("timeout_resp", res, '{9, 1, 9, 1, 0, 1'b1, 32'h0});

      run_seq(SW, 32'h40, 32'h5A5A_5A5A, 32'h0, 32'h0, 32'h0, 12, res);
      cmp_seq("timeout_req", res, '{9, 8, 9, 1, 0, 1'b1, 32'h0});

      run_seq(LW, 32'h2000, 32'h0, 32'h2, 32'h100, 32'hFEED_0001, 12, res);
      cmp_seq("rvalid_at_timeout", res, '{9, 1, 9, 1, 0, 1'b0, 32'hFEED_0001});

      run_seq(ADD, 32'h1000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 5, res);
      cmp_seq("non_mem_op", res, '{0, 0, -1, 0, 0, 1'b0, 32'h0});

      // Asynchronous reset while waiting for the response.
      ex_valid_i = 1'b1;
      ALUop_i    = LW;
      ALUOut     = 32'h1000;
      @(posedge clk);
      #1;
      mem_gnt_i = 1'b1;
      @(posedge clk);
      #1;
      mem_gnt_i = 1'b0;
      #1;
      check("pre_reset_in_resp", {30'd0, stall_o, mem_req_o}, 32'd2);
      #1;
      rst_n      = 1'b0;
      ex_valid_i = 1'b0;
      #1;
      check_all_zero("midreset");
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h0BAD_0BAD;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("post_reset_done", {30'd0, lsu_done_o, stall_o}, 32'd0);
      @(posedge clk);
      #1;
      drive_idle();
      run_seq(LW, 32'h1000, 32'h0, 32'h2, 32'h4, 32'h600D_CAFE, 8, res);
      cmp_seq("lw_after_reset", res, '{3, 1, 3, 1, 0, 1'b0, 32'h600D_CAFE});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
